// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data stages,
// data-first arbitration with a streak guard that stops fetch from starving.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        owner,
  output logic              stall_fetch,
  output logic              stall_mem
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_streak;
  logic [1:0] r_who;
  logic r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic w_if_cand, w_d_cand, w_gnt_f, w_gnt_d, w_fin;
  // r_who still names the just-served requester in RESP, so it is excluded there
  assign w_if_cand = if_req & ~(r_state == RESP & r_who == 2'b01);
  assign w_d_cand = d_req & ~(r_state == RESP & r_who == 2'b10);
  assign w_gnt_d = r_state != BUSY & w_d_cand & ~(w_if_cand & r_streak == SW'(MAX_DATA_STREAK));
  assign w_gnt_f = r_state != BUSY & w_if_cand & ~w_gnt_d;
  assign w_fin = r_state == BUSY & mem_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == BUSY) ? (mem_ready ? RESP : BUSY) : ((w_gnt_f | w_gnt_d) ? BUSY : IDLE);
  always_comb begin
    mem_req = r_state == BUSY;
    owner = (r_state == BUSY) ? r_who : 2'b00;
    if_done = r_state == RESP & r_who == 2'b01;
    d_done = r_state == RESP & r_who == 2'b10;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_who <= 2'b00;
      r_streak <= '0;
      r_mem_we <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_if_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_gnt_f | w_gnt_d) begin
        r_who <= w_gnt_d ? 2'b10 : 2'b01;
        r_mem_we <= w_gnt_d & d_we;
        r_mem_addr <= w_gnt_d ? d_addr : if_addr;
        r_mem_wdata <= w_gnt_d ? d_wdata : r_mem_wdata;
        r_streak <= (w_gnt_f | ~if_req) ? '0 : (r_streak == SW'(MAX_DATA_STREAK)) ? r_streak : r_streak + SW'(1);
      end
      if (w_fin & r_who == 2'b01) r_if_rdata <= mem_rdata;
      if (w_fin & r_who == 2'b10) r_d_rdata <= mem_rdata;
    end
  assign mem_we = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata = r_if_rdata;
  assign d_rdata = r_d_rdata;
  assign stall_fetch = if_req & ~if_done;
  assign stall_mem = d_req & ~d_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-level model checked every cycle.
// MAX_DATA_STREAK=1 so the starvation guard is reachable under the req/done protocol.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAX = 1;
  logic clk = 0, rst_n = 1;
  logic if_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [AW-1:0] if_addr = 0, d_addr = 0;
  logic [DW-1:0] d_wdata = 0, mem_rdata = 0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic if_done, d_done, mem_req, mem_we, stall_fetch, stall_mem;
  logic [1:0] owner;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .owner(owner), .stall_fetch(stall_fetch), .stall_mem(stall_mem));

  int checks = 0, failures = 0, cyc = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc++;

  // memory: ready after lat wait states; noise mode drives random ready/rdata
  int lat = 0, wcnt = 0;
  bit noise = 0;
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return (a == 100) ? 32'h20010005 : (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  always @(posedge clk) begin
    #1;
    if (noise) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end else if (mem_ready) mem_ready = 0;
    else if (mem_req) begin
      if (wcnt >= lat) begin
        mem_ready = 1;
        mem_rdata = mem_val(mem_addr);
        wcnt = 0;
      end else wcnt++;
    end
  end

  // requesters: hold req until done, then drop or re-raise with the next queued access
  typedef struct {logic we; logic [AW-1:0] a; logic [DW-1:0] w;} dreq_t;
  logic [AW-1:0] fq[$];
  dreq_t dq[$];
  bit f_seen = 0, d_seen = 0;
  always @(negedge clk) begin
    f_seen = if_done;
    d_seen = d_done;
  end
  always @(posedge clk) begin
    dreq_t t;
    #1;
    if (f_seen) begin if_req = 0; f_seen = 0; end
    if (d_seen) begin d_req = 0; d_seen = 0; end
    if (!if_req && fq.size() > 0 && rst_n) begin if_addr = fq.pop_front(); if_req = 1; end
    if (!d_req && dq.size() > 0 && rst_n) begin
      t = dq.pop_front();
      d_we = t.we; d_addr = t.a; d_wdata = t.w; d_req = 1;
    end
  end

  // model: one outstanding transaction (m_who), a done owner for one cycle, streak rules
  int m_who = 0, m_done = 0, m_streak = 0;
  logic m_we = 0;
  logic [AW-1:0] m_addr = 0;
  logic [DW-1:0] m_wdata = 0, m_ifr = 0, m_dr = 0;
  int gnt_log[$];
  always @(posedge clk or negedge rst_n) begin
    int served;
    bit fc, dc;
    if (!rst_n) begin
      m_who = 0; m_done = 0; m_streak = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_ifr = 0; m_dr = 0;
    end else begin
      served = m_done;
      m_done = 0;
      if (m_who != 0) begin
        if (mem_ready) begin
          if (m_who == 1) m_ifr = mem_rdata; else m_dr = mem_rdata;
          m_done = m_who;
          m_who = 0;
        end
      end else begin
        fc = if_req && served != 1;
        dc = d_req && served != 2;
        if (dc && !(fc && m_streak == MAX)) begin
          m_who = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
          m_streak = if_req ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
          gnt_log.push_back(2);
        end else if (fc) begin
          m_who = 1; m_addr = if_addr; m_we = 0; m_streak = 0;
          gnt_log.push_back(1);
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("mem_req", mem_req, m_who != 0);
    chk("owner", owner, m_who);
    if (m_who != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_done", if_done, m_done == 1);
    chk("d_done", d_done, m_done == 2);
    chk("if_rdata", if_rdata, m_ifr);
    chk("d_rdata", d_rdata, m_dr);
    chk("stall_fetch", stall_fetch, if_req && m_done != 1);
    chk("stall_mem", stall_mem, d_req && m_done != 2);
  end

  int first_own, n_fd, n_dd, n_busy, c_dd, c_f1;
  task automatic watch(input int n);
    first_own = 0; n_fd = 0; n_dd = 0; n_busy = 0; c_dd = -1; c_f1 = -1;
    repeat (n) begin
      @(negedge clk);
      if (first_own == 0) first_own = owner;
      n_fd += int'(if_done); n_dd += int'(d_done); n_busy += int'(mem_req);
      if (d_done && c_dd < 0) c_dd = cyc;
      if (owner == 2'b01 && c_f1 < 0) c_f1 = cyc;
    end
  endtask
  function automatic int enc();
    int e = 0;
    foreach (gnt_log[i]) e = e * 10 + gnt_log[i];
    return e;
  endfunction

  initial begin
    int t_req, at;
    #1 rst_n = 0;
    @(negedge clk); #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_owner", owner, 0);
    chk("rst_if_rdata", if_rdata, 0);
    @(negedge clk); #2 rst_n = 1;

    // single zero-wait fetch
    lat = 0;
    @(negedge clk); fq.push_back(100);
    @(posedge clk); #2 t_req = cyc;
    @(negedge clk); @(negedge clk);
    chk("fetch_mem_addr", mem_addr, 100);
    chk("fetch_mem_we", mem_we, 0);
    at = -1;
    for (int i = 0; i < 10 && at < 0; i++) begin @(negedge clk); if (if_done) at = cyc; end
    chk("fetch_latency", at - t_req, 2);
    chk("fetch_rdata", if_rdata, 32'h20010005);
    chk("fetch_stall_in_done", stall_fetch, 0);
    repeat (3) @(negedge clk);

    // store with two wait states
    lat = 2;
    dq.push_back('{1'b1, 32'h40, 32'hDEADBEEF});
    watch(12);
    chk("store_busy_cycles", n_busy, 3);
    chk("store_done_pulses", n_dd, 1);
    chk("store_owner_after", owner, 0);

    // contention: data first, fetch granted straight from RESP
    lat = 0;
    gnt_log.delete();
    fq.push_back(32'h200);
    dq.push_back('{1'b0, 32'h80, 32'h0});
    watch(12);
    chk("cont_first_owner", first_own, 2);
    chk("cont_fetch_after_ddone", c_f1 - c_dd, 1);
    chk("cont_ddone_count", n_dd, 1);
    chk("cont_fdone_count", n_fd, 1);
    chk("cont_grant_order", enc(), 21);
    chk("cont_load_rdata", d_rdata, mem_val(32'h80));

    // streak guard: data granted while served fetch still requests, then fetch must win
    lat = 1;
    gnt_log.delete();
    fq.push_back(32'h300);
    repeat (2) @(negedge clk);
    dq.push_back('{1'b1, 32'h90, 32'h12345678});
    watch(10);
    chk("guard_setup_order", enc(), 12);
    gnt_log.delete();
    fq.push_back(32'h304);
    dq.push_back('{1'b0, 32'hA0, 32'h0});
    watch(12);
    chk("guard_fetch_first", first_own, 1);
    chk("guard_order", enc(), 12);
    // a data grant with fetch idle clears the streak; data priority resumes
    gnt_log.delete();
    dq.push_back('{1'b0, 32'hB0, 32'h0});
    watch(8);
    fq.push_back(32'h308);
    dq.push_back('{1'b1, 32'hB4, 32'hCAFEF00D});
    watch(12);
    chk("resume_data_first", first_own, 2);
    chk("resume_order", enc(), 221);

    // reset while busy
    lat = 5;
    fq.push_back(32'h400);
    at = -1;
    for (int i = 0; i < 10 && at < 0; i++) begin @(negedge clk); if (mem_req) at = cyc; end
    chk("rst_busy_reached", at >= 0, 1);
    #2 rst_n = 0;
    fq.delete(); if_req = 0; d_req = 0; f_seen = 0; d_seen = 0; wcnt = 0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_d_rdata", d_rdata, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk); #2 mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
    watch(4);
    chk("stray_ready_done", n_fd + n_dd, 0);
    chk("stray_ready_busy", n_busy, 0);

    // idle stability under memory noise
    lat = 0;
    fq.push_back(100);
    watch(6);
    noise = 1;
    watch(20);
    noise = 0;
    @(posedge clk); #2 mem_ready = 0;
    chk("idle_busy", n_busy, 0);
    chk("idle_done", n_fd + n_dd, 0);
    chk("idle_if_rdata", if_rdata, 32'h20010005);
    chk("idle_d_rdata", d_rdata, 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
